// File: rtl/iob_soc_sut_iob_arbiter_if.sv
// rtl/iob_soc_sut_iob_arbiter_if.sv - IOb native bus bundle with master/slave views
interface iob_soc_sut_iob_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic                  avalid;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     rdata;
  logic                  ready;
  logic                  rvalid;

  modport master (output avalid, addr, wdata, wstrb, input rdata, ready, rvalid);
  modport slave  (input avalid, addr, wdata, wstrb, output rdata, ready, rvalid);
endinterface

// File: rtl/iob_soc_sut_iob_arbiter.sv
// rtl/iob_soc_sut_iob_arbiter.sv - two-master round-robin IOb arbiter with read watchdog
module iob_soc_sut_iob_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                          clk_i,
  input  logic                          arst_n_i,
  iob_soc_sut_iob_arbiter_if.slave      m0_iob,
  iob_soc_sut_iob_arbiter_if.slave      m1_iob,
  iob_soc_sut_iob_arbiter_if.master     s_iob,
  output logic [1:0]                    grant_o,
  output logic                          timeout_o
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_RESP = 2'd2} state_t;

  localparam logic [TIMEOUT_W-1:0] WDOG_MAX = '1;

  state_t                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic                  last_q, last_d;
  logic [TIMEOUT_W-1:0]  wdog_q, wdog_d;
  logic                  timeout_q, timeout_d;

  logic                  pick_m1;
  logic                  done;
  logic                  to_fire;
  logic                  fwd_ready;
  logic                  fwd_rvalid;
  logic [DATA_W-1:0]     fwd_rdata;

  logic                  in_req;
  logic                  req_avalid;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wstrb;

  assign in_req     = (state_q == ST_REQ);
  assign req_avalid = grant_q[1] ? m1_iob.avalid : m0_iob.avalid;
  assign req_addr   = grant_q[1] ? m1_iob.addr   : m0_iob.addr;
  assign req_wdata  = grant_q[1] ? m1_iob.wdata  : m0_iob.wdata;
  assign req_wstrb  = grant_q[1] ? m1_iob.wstrb  : m0_iob.wstrb;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    wdog_d     = wdog_q;
    timeout_d  = timeout_q;
    pick_m1    = 1'b0;
    done       = 1'b0;
    to_fire    = 1'b0;
    fwd_ready  = 1'b0;
    fwd_rvalid = 1'b0;
    fwd_rdata  = '0;
    case (state_q)
      ST_IDLE: begin
        if (m0_iob.avalid || m1_iob.avalid) begin
          // contention goes to whoever was not served last
          pick_m1 = (m0_iob.avalid && m1_iob.avalid) ? ~last_q : m1_iob.avalid;
          grant_d = pick_m1 ? 2'b10 : 2'b01;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        fwd_ready = s_iob.ready;
        if (s_iob.ready) begin
          if (req_wstrb != '0) begin
            done = 1'b1;
          end else if (s_iob.rvalid) begin
            fwd_rvalid = 1'b1;
            fwd_rdata  = s_iob.rdata;
            done       = 1'b1;
          end else begin
            state_d = ST_RESP;
            wdog_d  = '0;
          end
        end
      end
      ST_RESP: begin
        wdog_d    = wdog_q + 1'b1;
        fwd_rdata = s_iob.rdata;
        // real slave data takes priority over a coincident watchdog expiry
        if (s_iob.rvalid) begin
          fwd_rvalid = 1'b1;
          done       = 1'b1;
        end else if (wdog_q == WDOG_MAX) begin
          fwd_rvalid = 1'b1;
          fwd_rdata  = '0;
          to_fire    = 1'b1;
          timeout_d  = 1'b1;
          done       = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (done) begin
      state_d = ST_IDLE;
      grant_d = 2'b00;
      last_d  = grant_q[1];
    end
  end

  assign s_iob.avalid = in_req & req_avalid;
  assign s_iob.addr   = in_req ? req_addr  : '0;
  assign s_iob.wdata  = in_req ? req_wdata : '0;
  assign s_iob.wstrb  = in_req ? req_wstrb : '0;

  assign m0_iob.ready  = fwd_ready  & grant_q[0];
  assign m0_iob.rvalid = fwd_rvalid & grant_q[0];
  assign m0_iob.rdata  = grant_q[0] ? fwd_rdata : '0;
  assign m1_iob.ready  = fwd_ready  & grant_q[1];
  assign m1_iob.rvalid = fwd_rvalid & grant_q[1];
  assign m1_iob.rdata  = grant_q[1] ? fwd_rdata : '0;

  assign grant_o   = grant_q;
  assign timeout_o = timeout_q | to_fire;

endmodule

// File: doc/iob_soc_sut_iob_arbiter.md
Name: iob_soc_sut_iob_arbiter

Overview:
- Two-master, one-slave arbiter on the IOb native bus.
- Lets two requesters share one IOb slave, e.g. the testbench UART register port:
  - master 0: simulation host driver
  - master 1: auxiliary sequencer
- Round-robin grant, at most one outstanding transaction, and a read-response watchdog so that a hung slave cannot lock the bus.

Parameters:
ADDR_W, 16, IOb address width (matches UART swreg address width)
DATA_W, 32, IOb data width; wstrb width is DATA_W/8
TIMEOUT_W, 8, watchdog counter width; read timeout = 2**TIMEOUT_W-1 cycles

Ports:
clk_i  input  1  system clock
arst_n_i  input  1  reset, asynchronous, active-low
m0_iob_avalid_i  input  1  master 0 request valid
m0_iob_addr_i  input  ADDR_W  master 0 address
m0_iob_wdata_i  input  DATA_W  master 0 write data
m0_iob_wstrb_i  input  DATA_W/8  master 0 byte strobes (0 = read)
m0_iob_rdata_o  output  DATA_W  master 0 read data
m0_iob_ready_o  output  1  master 0 request accepted
m0_iob_rvalid_o  output  1  master 0 read data valid
m1_iob_* (same seven signals as m0)  -  -  master 1 port
s_iob_avalid_o  output  1  slave request valid
s_iob_addr_o  output  ADDR_W  slave address
s_iob_wdata_o  output  DATA_W  slave write data
s_iob_wstrb_o  output  DATA_W/8  slave strobes
s_iob_rdata_i  input  DATA_W  slave read data
s_iob_ready_i  input  1  slave accepted request
s_iob_rvalid_i  input  1  slave read data valid
grant_o  output  2  one-hot current owner (00 = none)
timeout_o  output  1  sticky: a read watchdog expired

Behaviour:
- Reset (arst_n_i low, asynchronous): state IDLE, grant_o=00, last-served pointer=1 (so master 0 wins first), watchdog=0, timeout_o=0.
  - All outputs are 0 during reset: s_iob_*, m*_ready/rvalid/rdata.
  - Reset deasserts synchronously to clk_i.
- Masters follow IOb rules: a master holds avalid/addr/wdata/wstrb stable until it sees ready.
- Arbitration is registered. In IDLE, on a clock edge with any avalid high:
  - grant = requester not equal to last-served.
  - If only one requester, grant it.
  - Go to REQ.
  - Request-to-slave latency is one cycle after avalid.
- REQ:
  - s_iob_* = granted master's signals (mux by grant_o); the non-granted master's avalid is ignored.
  - Granted ready_o = s_iob_ready_i; other ready_o = 0.
  - On s_iob_ready_i:
    - write (wstrb != 0): go to IDLE, update last-served, grant_o=00.
    - read (wstrb == 0): go to RESP, watchdog cleared.
- RESP:
  - s_iob_avalid_o=0; watchdog increments each cycle.
  - Granted rdata_o = s_iob_rdata_i and rvalid_o = s_iob_rvalid_i; other master sees rdata=0, rvalid=0.
  - On s_iob_rvalid_i: go to IDLE, update last-served.
  - If the watchdog reaches 2**TIMEOUT_W-1 with no rvalid, in that cycle:
    - granted rvalid_o=1, rdata_o=0;
    - timeout_o set;
    - go to IDLE, update last-served.
  - If rvalid and timeout coincide, slave data wins and timeout_o is not set.
- A slave rvalid arriving while not in RESP is dropped.
- Single-cycle ready+rvalid for a read in REQ:
  - rvalid is forwarded to the granted master in the same cycle;
  - go directly to IDLE, skipping RESP.
- Fairness: with both masters continuously requesting, grants alternate 0,1,0,1.
- Max one transaction in flight; IDLE always lasts at least one cycle between transactions.
- timeout_o clears only on reset.
- A master dropping avalid in REQ is a protocol violation; the arbiter keeps forwarding the mux output until ready.

Test Plan:
- Master 0 writes addr 0x0004, wdata 0x000000A5, wstrb 0xF; slave ready next cycle.
  - Required: s_iob_avalid_o rises 1 cycle after m0 avalid; m0 ready pulses once; grant_o returns to 00; m1 outputs all 0.
- Both masters request reads on the same cycle after reset; slave returns 0x11 then 0x22.
  - Required: m0 is served first and gets 0x11; m1 is served next and gets 0x22; grant_o sequence 01,00,10,00.
- Both masters hold writes continuously for 6 transactions.
  - Required: grant order 0,1,0,1,0,1; no back-to-back grants to the same master.
- Master 1 reads with TIMEOUT_W=4 and the slave never asserts rvalid.
  - Required: m1 rvalid=1 with rdata=0 exactly 15 cycles after entering RESP; timeout_o=1 and stays high; next request is served normally.
- Slave asserts ready and rvalid in the same cycle with rdata 0xDEADBEEF for an m0 read.
  - Required: m0 ready and rvalid both high in that cycle with 0xDEADBEEF; state IDLE next cycle.
- arst_n_i pulsed low mid-RESP.
  - Required: all outputs 0 immediately; grant_o=00; timeout_o=0; the next simultaneous request is granted to m0.
